// File: rtl/uart_core.sv
// Parametrised full-duplex UART engine with valid/ready streams on both sides.
// Optional internal TX->RX loopback is enabled by defining UART_CORE_LOOPBACK_EN.
module uart_core #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
`ifdef UART_CORE_LOOPBACK_EN
  ,
  input  logic                 loopback
`endif
);

  localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   MID_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY == 1);
  localparam logic            HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e               tx_state_q;
  logic [CW-1:0]           tx_cnt_q;
  logic [2:0]              tx_idx_q;
  logic [DATA_BITS-1:0]    tx_sh_q;
  logic                    tx_par_q;
  logic                    tx_line_q;
  logic                    tx_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (tx_valid && tx_ready_q) begin
          tx_sh_q    <= tx_data;
          tx_par_q   <= (^tx_data) ^ ODD;
          tx_line_q  <= 1'b0;
          tx_ready_q <= 1'b0;
          tx_cnt_q   <= '0;
          tx_state_q <= TX_START;
        end
        TX_START: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q   <= '0;
          tx_idx_q   <= '0;
          tx_line_q  <= tx_sh_q[0];
          tx_sh_q    <= tx_sh_q >> 1;
          tx_state_q <= TX_DATA;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        TX_DATA: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_q   <= '0;
            tx_line_q  <= HAS_PAR ? tx_par_q : 1'b1;
            tx_state_q <= HAS_PAR ? TX_PAR : TX_STOP;
          end else begin
            tx_idx_q  <= tx_idx_q + 3'd1;
            tx_line_q <= tx_sh_q[0];
            tx_sh_q   <= tx_sh_q >> 1;
          end
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        TX_PAR: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q   <= '0;
          tx_line_q  <= 1'b1;
          tx_state_q <= TX_STOP;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        TX_STOP: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_idx_q == STOP_LAST) begin
            tx_idx_q   <= '0;
            tx_ready_q <= 1'b1;
            tx_state_q <= TX_IDLE;
          end else tx_idx_q <= tx_idx_q + 3'd1;
        end else tx_cnt_q <= tx_cnt_q + CW'(1);
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  logic                    rx_in;
  logic [1:0]              sync_q;
  logic                    rxs;
  rx_state_e               rx_state_q;
  logic [CW-1:0]           rx_cnt_q;
  logic [2:0]              rx_idx_q;
  logic [DATA_BITS-1:0]    rx_sh_q;
  logic                    rx_perr_q;
  logic                    rx_ferr_q;
  logic                    rx_fe_now;
  logic [DATA_BITS-1:0]    rx_data_q;
  logic                    rx_valid_q;
  logic                    rx_pe_q;
  logic                    rx_fe_q;
  logic                    rx_ov_q;

`ifdef UART_CORE_LOOPBACK_EN
  assign rx_in   = loopback ? tx_line_q : uart_rx;
  assign uart_tx = loopback ? 1'b1 : tx_line_q;
`else
  assign rx_in   = uart_rx;
  assign uart_tx = tx_line_q;
`endif

  assign rxs       = sync_q[1];
  assign rx_fe_now = rx_ferr_q | ~rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_ov_q    <= 1'b0;
    end else begin
      rx_ov_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rxs) begin
          rx_cnt_q   <= '0;
          rx_state_q <= RX_START;
        end
        // Detection already cost one cycle, so this lands CLKS_PER_BIT/2 into the bit
        RX_START: if (rx_cnt_q == MID_LAST) begin
          rx_cnt_q <= '0;
          if (rxs) rx_state_q <= RX_IDLE;
          else begin
            rx_idx_q   <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_state_q <= RX_DATA;
          end
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_DATA: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rxs, rx_sh_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) begin
            rx_idx_q   <= '0;
            rx_state_q <= HAS_PAR ? RX_PAR : RX_STOP;
          end else rx_idx_q <= rx_idx_q + 3'd1;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_PAR: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q   <= '0;
          rx_perr_q  <= rxs ^ (^rx_sh_q) ^ ODD;
          rx_state_q <= RX_STOP;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_STOP: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q <= '0;
          if (rx_idx_q == STOP_LAST) begin
            rx_idx_q   <= '0;
            rx_state_q <= rx_fe_now ? RX_WAIT_HIGH : RX_IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= rx_sh_q;
              rx_pe_q    <= rx_perr_q;
              rx_fe_q    <= rx_fe_now;
              rx_valid_q <= 1'b1;
            end else rx_ov_q <= 1'b1;
          end else begin
            rx_ferr_q <= rx_fe_now;
            rx_idx_q  <= rx_idx_q + 3'd1;
          end
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_WAIT_HIGH: if (rxs) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_pe_q;
  assign rx_frame_err  = rx_fe_q;
  assign rx_overrun    = rx_ov_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: an 8N1 instance and a 7E2 instance, both at 4 clocks per bit.
module tb_uart_core;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lb  = 1'b0;

  logic       rx8 = 1'b1, tv8 = 1'b0, rr8 = 1'b1;
  logic [7:0] td8 = '0;
  logic       ut8, tr8, rv8, pe8, fe8, ov8;
  logic [7:0] rd8;

  logic       rx7 = 1'b1, tv7 = 1'b0, rr7 = 1'b1;
  logic [6:0] td7 = '0;
  logic       ut7, tr7, rv7, pe7, fe7, ov7;
  logic [6:0] rd7;

  always #5 clk = ~clk;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8 (
    .clk(clk), .rst(rst), .uart_rx(rx8), .uart_tx(ut8),
    .tx_data(td8), .tx_valid(tv8), .tx_ready(tr8),
    .rx_data(rd8), .rx_valid(rv8), .rx_ready(rr8),
    .rx_parity_err(pe8), .rx_frame_err(fe8), .rx_overrun(ov8)
`ifdef UART_CORE_LOOPBACK_EN
    , .loopback(lb)
`endif
  );

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u7 (
    .clk(clk), .rst(rst), .uart_rx(rx7), .uart_tx(ut7),
    .tx_data(td7), .tx_valid(tv7), .tx_ready(tr7),
    .rx_data(rd7), .rx_valid(rv7), .rx_ready(rr7),
    .rx_parity_err(pe7), .rx_frame_err(fe7), .rx_overrun(ov7)
`ifdef UART_CORE_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Capture every accepted output word and every overrun pulse
  int         v8_n = 0, ov8_n = 0, v7_n = 0, ov7_n = 0;
  logic [7:0] d8c = '0;
  logic       pe8c = 1'b0, fe8c = 1'b0;
  logic [6:0] d7c = '0;
  logic       pe7c = 1'b0, fe7c = 1'b0;

  always @(negedge clk) begin
    if (rv8 && rr8) begin v8_n++; d8c = rd8; pe8c = pe8; fe8c = fe8; end
    if (ov8) ov8_n++;
    if (rv7 && rr7) begin v7_n++; d7c = rd7; pe7c = pe7; fe7c = fe7; end
    if (ov7) ov7_n++;
  end

  task automatic send_tx(input bit sel, input logic [7:0] d, input logic [15:0] frame,
                         input int nbits, input string tag);
    @(negedge clk);
    if (sel) begin td7 = d[6:0]; tv7 = 1'b1; end
    else     begin td8 = d;      tv8 = 1'b1; end
    @(negedge clk);
    tv7 = 1'b0; tv8 = 1'b0;
    td7 = ~d[6:0]; td8 = ~d;
    for (int i = 0; i < nbits * CPB; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_line"}, sel ? ut7 : ut8, frame[i / CPB]);
      check({tag, "_busy"}, sel ? tr7 : tr8, 1'b0);
    end
    @(negedge clk);
    check({tag, "_ready_back"}, sel ? tr7 : tr8, 1'b1);
    check({tag, "_idle_line"},  sel ? ut7 : ut8, 1'b1);
  endtask

  task automatic drive_rx(input bit sel, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel) rx7 = bits[i];
      else     rx8 = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    int zeros;
    repeat (3) @(negedge clk);
    check("rst_tx8",    ut8, 1'b1);
    check("rst_rdy8",   tr8, 1'b1);
    check("rst_rv8",    rv8, 1'b0);
    check("rst_rd8",    rd8, 8'h00);
    check("rst_pe8",    pe8, 1'b0);
    check("rst_fe8",    fe8, 1'b0);
    check("rst_ov8",    ov8, 1'b0);
    check("rst_tx7",    ut7, 1'b1);
    check("rst_rdy7",   tr7, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_tx(1'b0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "tx8n1_a5");
    send_tx(1'b1, 8'h41, {5'b0, 2'b11, 1'b0, 7'h41, 1'b0}, 11, "tx7e2_41");

    // 0x43 has three ones: even parity bit is 1, so a 0 is a parity error
    drive_rx(1'b1, {5'b0, 2'b11, 1'b0, 7'h43, 1'b0}, 11);
    rx7 = 1'b1; repeat (8) @(negedge clk);
    check("rx7_cnt1",  v7_n, 1);
    check("rx7_data1", d7c, 7'h43);
    check("rx7_pe1",   pe7c, 1'b1);
    check("rx7_fe1",   fe7c, 1'b0);

    drive_rx(1'b1, {5'b0, 2'b11, 1'b1, 7'h43, 1'b0}, 11);
    rx7 = 1'b1; repeat (8) @(negedge clk);
    check("rx7_cnt2",  v7_n, 2);
    check("rx7_pe2",   pe7c, 1'b0);

    // second stop bit low only
    drive_rx(1'b1, {5'b0, 2'b01, 1'b1, 7'h15, 1'b0}, 11);
    rx7 = 1'b1; repeat (8) @(negedge clk);
    check("rx7_cnt3",  v7_n, 3);
    check("rx7_data3", d7c, 7'h15);
    check("rx7_fe3",   fe7c, 1'b1);
    check("rx7_pe3",   pe7c, 1'b0);

    drive_rx(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (8) @(negedge clk);
    check("rx8_cnt_3c",  v8_n, 1);
    check("rx8_data_3c", d8c, 8'h3C);
    check("rx8_pe_3c",   pe8c, 1'b0);
    check("rx8_fe_3c",   fe8c, 1'b0);
    check("rx8_pulse",   rv8, 1'b0);

    drive_rx(1'b0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    repeat (20) @(negedge clk);
    check("brk_cnt",  v8_n, 2);
    check("brk_fe",   fe8c, 1'b1);
    check("brk_data", d8c, 8'h3C);
    rx8 = 1'b1;
    repeat (60) @(negedge clk);
    check("brk_no_second", v8_n, 2);

    rx8 = 1'b0; @(negedge clk); rx8 = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_cnt", v8_n, 2);
    drive_rx(1'b0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
    repeat (8) @(negedge clk);
    check("post_glitch_cnt",  v8_n, 3);
    check("post_glitch_data", d8c, 8'h96);
    check("post_glitch_fe",   fe8c, 1'b0);

    rr8 = 1'b0;
    drive_rx(1'b0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    drive_rx(1'b0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    repeat (8) @(negedge clk);
    check("ovr_valid", rv8, 1'b1);
    check("ovr_data",  rd8, 8'h11);
    check("ovr_pulses", ov8_n, 1);
    @(posedge clk); #1 rr8 = 1'b1;
    @(negedge clk);
    check("ovr_valid_hold", rv8, 1'b1);
    @(negedge clk);
    check("ovr_valid_drop", rv8, 1'b0);
    repeat (2) @(negedge clk);
    check("ovr_taken_cnt",  v8_n, 4);
    check("ovr_taken_data", d8c, 8'h11);

    @(negedge clk); td8 = 8'h00; tv8 = 1'b1;
    @(negedge clk); tv8 = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_line", ut8, 1'b0);
    check("pre_rst_busy", tr8, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_line", ut8, 1'b1);
    check("mid_rst_rdy",  tr8, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_rv", rv8, 1'b0);

`ifdef UART_CORE_LOOPBACK_EN
    lb = 1'b1;
    @(negedge clk); td8 = 8'h5A; tv8 = 1'b1;
    @(negedge clk); tv8 = 1'b0;
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      if (ut8 !== 1'b1) zeros++;
      @(negedge clk);
    end
    check("lb_pin_high", zeros, 0);
    check("lb_cnt",  v8_n, 5);
    check("lb_data", d8c, 8'h5A);
    check("lb_fe",   fe8c, 1'b0);
    lb = 1'b0;
`else
    zeros = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
